// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues instruction-memory
// requests, keeps returned words in a small in-order prefetch queue and
// drives the IF/ID pipeline register.
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_bubbles counter.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallf,
    input  logic        stalld,
    input  logic        flushd,
    input  logic [1:0]  pcsrce,
    input  logic [31:0] pctargete,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrd,
    output logic [31:0] pcd,
    output logic [31:0] pcplus4d,
    output logic        validd
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_bubbles
`endif
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    // Wide enough for every response the memory can still owe us after
    // several back-to-back redirects.
    localparam int unsigned DROP_W = 8;

    localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    // Program counter and queue bookkeeping
    logic [31:0]       pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  filled_q, filled_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    // Slot storage: request PC and returned word per slot
    logic [31:0] slotPc_q   [DEPTH];
    logic [31:0] slotWord_q [DEPTH];

    // IF/ID pipeline register
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    // Control decode
    logic             redirect;
    logic [CNT_W-1:0] unfilled;
    logic             headFilled;
    logic             pop;
    logic             accept;
    logic             dropActive;
    logic             fill;
    logic             rspCountsAsDrop;
    logic [PTR_W-1:0] fillIdx;

    assign redirect   = |pcsrce;
    assign unfilled   = count_q - filled_q;
    // Slots fill strictly in order, so the head is filled whenever any slot is.
    assign headFilled = (filled_q != '0);
    assign pop        = headFilled && !redirect && !flushd && !stalld;
    assign imem_req   = rst_n && !stallf && !redirect &&
                        ((count_q < DEPTH_C) || pop);
    assign imem_addr  = pc_q;
    assign accept     = imem_req && imem_ready;
    assign dropActive = (drop_q != '0);
    assign fill       = imem_rvalid && !redirect && !dropActive &&
                        (unfilled != '0);
    // The oldest unfilled slot sits right after the filled run at the head.
    assign fillIdx    = head_q + filled_q[PTR_W-1:0];
    // A response in a redirect cycle belongs to either an older drop or one
    // of the slots being discarded right now.
    assign rspCountsAsDrop = imem_rvalid && (dropActive || (unfilled != '0));

    // Next PC: a redirect wins over everything, otherwise advance on acceptance.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = pctargete;
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Queue pointers, occupancy, fill count and pending-drop count.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        filled_d = filled_q;
        drop_d   = drop_q;
        if (redirect) begin
            tail_d   = head_q;
            count_d  = '0;
            filled_d = '0;
            drop_d   = drop_q + DROP_W'(unfilled) - DROP_W'(rspCountsAsDrop);
        end else begin
            if (imem_rvalid && dropActive) begin
                drop_d = drop_q - DROP_W'(1);
            end
            count_d  = count_q + CNT_W'(accept) - CNT_W'(pop);
            filled_d = filled_q + CNT_W'(fill) - CNT_W'(pop);
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (accept) begin
                tail_d = tail_q + PTR_W'(1);
            end
        end
    end

    // IF/ID next value: flush beats stall, stall beats load, else a bubble.
    always_comb begin
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flushd) begin
            instr_d   = NOP_INSTR;
            pcd_d     = '0;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end else if (stalld) begin
            instr_d   = instr_q;
        end else if (headFilled && !redirect) begin
            instr_d   = slotWord_q[head_q];
            pcd_d     = slotPc_q[head_q];
            pcplus4_d = slotPc_q[head_q] + 32'd4;
            valid_d   = 1'b1;
        end else begin
            instr_d   = NOP_INSTR;
            pcd_d     = '0;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end
    end

    // State registers for PC, queue bookkeeping and the IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            filled_q  <= '0;
            drop_q    <= '0;
            instr_q   <= NOP_INSTR;
            pcd_q     <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            filled_q  <= filled_d;
            drop_q    <= drop_d;
            instr_q   <= instr_d;
            pcd_q     <= pcd_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    // Slot payloads need no reset: occupancy counters say which are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            slotPc_q[tail_q] <= pc_q;
        end
        if (fill) begin
            slotWord_q[fillIdx] <= imem_rdata;
        end
    end

    assign instrd   = instr_q;
    assign pcd      = pcd_q;
    assign pcplus4d = pcplus4_q;
    assign validd   = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic        bubble;
    logic [31:0] bubbles_q, bubbles_d;

    assign bubble = !flushd && !stalld && !(headFilled && !redirect);

    // Saturating count of edges where IF/ID receives a bubble.
    always_comb begin
        bubbles_d = bubbles_q;
        if (bubble && (bubbles_q != 32'hFFFF_FFFF)) begin
            bubbles_d = bubbles_q + 32'd1;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubbles_q <= '0;
        end else begin
            bubbles_q <= bubbles_d;
        end
    end

    assign fetch_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: table-driven cycle vectors against a 1-cycle
// memory, plus hand-written redirect and back-pressure sequences.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallf, stalld, flushd;
    logic [1:0]  pcsrce;
    logic [31:0] pctargete;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrd, pcd, pcplus4d;
    logic        validd;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_bubbles;
`endif

    int checkCount = 0;
    int errorCount = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stallf      (stallf),
        .stalld      (stalld),
        .flushd      (flushd),
        .pcsrce      (pcsrce),
        .pctargete   (pctargete),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instrd      (instrd),
        .pcd         (pcd),
        .pcplus4d    (pcplus4d),
`ifdef FETCH_PERF_CNT_EN
        .fetch_bubbles (fetch_bubbles),
`endif
        .validd      (validd)
    );

    always #5 clk = ~clk;

    // Instruction memory model: in-order responses, programmable latency.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t memQ[$];
    int   memLat = 1;
    int   edgeNo = 0;

    function automatic logic [31:0] wordFor(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    // Record accepted requests and present each response one cycle before
    // the edge at which it is due.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memQ.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            edgeNo      <= 0;
        end else begin
            if (imem_req && imem_ready) begin
                memQ.push_back('{imem_addr, edgeNo + 1 + memLat});
            end
            if (memQ.size() > 0 && memQ[0].due <= edgeNo + 2) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= wordFor(memQ[0].addr);
                memQ.pop_front();
            end else begin
                imem_rvalid <= 1'b0;
            end
            edgeNo <= edgeNo + 1;
        end
    end

    typedef struct {
        logic        stallf;
        logic        stalld;
        logic        flushd;
        logic [1:0]  pcsrce;
        logic [31:0] target;
        logic        expReq;
        logic        expValid;
        logic [31:0] expPcd;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sf, input logic sd, input logic fd,
                                input logic [1:0] ps, input logic [31:0] tg,
                                input logic rq, input logic vl,
                                input logic [31:0] pc, input logic [31:0] ad);
        vec_t v;
        v.stallf = sf; v.stalld = sd; v.flushd = fd; v.pcsrce = ps; v.target = tg;
        v.expReq = rq; v.expValid = vl; v.expPcd = pc; v.expAddr = ad;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checkCount++;
        if (actual !== required) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        stallf    = v.stallf;
        stalld    = v.stalld;
        flushd    = v.flushd;
        pcsrce    = v.pcsrce;
        pctargete = v.target;
    endtask

    task automatic setIdle();
        stallf = 1'b0; stalld = 1'b0; flushd = 1'b0;
        pcsrce = 2'b00; pctargete = '0;
    endtask

    // Asserts reset, checks reset values, releases it at a falling edge.
    task automatic doReset(input int lat, input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        setIdle();
        memLat = lat;
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput({tag, " rst req"},    {31'b0, imem_req}, 32'h0);
        checkOutput({tag, " rst addr"},   imem_addr, 32'h0);
        checkOutput({tag, " rst instr"},  instrd, 32'h0000_0013);
        checkOutput({tag, " rst pcd"},    pcd, 32'h0);
        checkOutput({tag, " rst pc4"},    pcplus4d, 32'h0);
        checkOutput({tag, " rst valid"},  {31'b0, validd}, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] expInstr, expP4;
        logic [31:0] basePerf;
        int          found;
        int          latency;

        rst_n = 1'b0;
        imem_ready = 1'b1;
        setIdle();
        basePerf = '0;

        // Edges 1-6: reset stream; 7-10: decode stall; 14: flush+stall;
        // 17: flush alone; 20: redirect to 0x200; 25: redirect to the top
        // word so the PC wraps to zero.
        vecs.push_back(mk(0,0,0,2'b00,0, 1,0,32'h0,  32'h4));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,0,32'h0,  32'h8));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h0,  32'hC));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h4,  32'h10));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h8,  32'h14));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'hC,  32'h18));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,1,0,2'b00,0, 0,1,32'hC, 32'h18));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h10, 32'h1C));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h14, 32'h20));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h18, 32'h24));
        vecs.push_back(mk(0,1,1,2'b00,0, 0,0,32'h0,  32'h24));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h1C, 32'h28));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h20, 32'h2C));
        vecs.push_back(mk(0,0,1,2'b00,0, 0,0,32'h0,  32'h2C));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h24, 32'h30));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h28, 32'h34));
        vecs.push_back(mk(0,0,1,2'b10,32'h200, 0,0,32'h0, 32'h200));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,0,32'h0,   32'h204));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,0,32'h0,   32'h208));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h200, 32'h20C));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h204, 32'h210));
        vecs.push_back(mk(0,0,1,2'b01,32'hFFFF_FFFC, 0,0,32'h0, 32'hFFFF_FFFC));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,0,32'h0,         32'h0));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,0,32'h0,         32'h4));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'hFFFF_FFFC, 32'h8));
        vecs.push_back(mk(0,0,0,2'b00,0, 1,1,32'h0,         32'hC));

        doReset(1, "table");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            stepEdge();
            expInstr = vecs[i].expValid ? wordFor(vecs[i].expPcd) : 32'h0000_0013;
            expP4    = vecs[i].expValid ? vecs[i].expPcd + 32'd4 : 32'h0;
            checkOutput($sformatf("vec%0d req", i + 1),   {31'b0, imem_req}, {31'b0, vecs[i].expReq});
            checkOutput($sformatf("vec%0d addr", i + 1),  imem_addr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d valid", i + 1), {31'b0, validd}, {31'b0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d pcd", i + 1),   pcd, vecs[i].expPcd);
            checkOutput($sformatf("vec%0d pc4", i + 1),   pcplus4d, expP4);
            checkOutput($sformatf("vec%0d instr", i + 1), instrd, expInstr);
            @(negedge clk);
        end
        setIdle();

        // Redirect with two requests outstanding on a 3-cycle memory.
        doReset(3, "redir");
        stepEdge();
        stepEdge();
        checkOutput("redir inflight req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        pcsrce = 2'b01;
        pctargete = 32'h100;
        stepEdge();
        checkOutput("redir addr", imem_addr, 32'h100);
        @(negedge clk);
        setIdle();
        #1;
        checkOutput("redir req after", {31'b0, imem_req}, 32'h1);
        found = 0;
        latency = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            stepEdge();
            if (validd) begin
                found = 1;
                latency = k;
            end
        end
        checkOutput("redir valid seen", found, 32'd1);
        if (found != 0) begin
            checkOutput("redir latency", latency, 32'd4);
            checkOutput("redir pcd0",   pcd, 32'h100);
            checkOutput("redir instr0", instrd, wordFor(32'h100));
            stepEdge();
            checkOutput("redir valid1", {31'b0, validd}, 32'h1);
            checkOutput("redir pcd1",   pcd, 32'h104);
            checkOutput("redir instr1", instrd, wordFor(32'h104));
        end

        // Memory back-pressure for 5 cycles on a 1-cycle memory.
        doReset(1, "bp");
        repeat (6) stepEdge();
        checkOutput("bp warm pcd", pcd, 32'hC);
`ifdef FETCH_PERF_CNT_EN
        basePerf = fetch_bubbles;
        checkOutput("perf startup", basePerf, 32'd2);
`endif
        @(negedge clk);
        imem_ready = 1'b0;
        for (int e = 7; e <= 11; e++) begin
            stepEdge();
            checkOutput($sformatf("bp e%0d addr", e), imem_addr, 32'h18);
            if (e <= 8) begin
                checkOutput($sformatf("bp e%0d valid", e), {31'b0, validd}, 32'h1);
                checkOutput($sformatf("bp e%0d pcd", e), pcd, 32'h10 + 32'(4 * (e - 7)));
            end else begin
                checkOutput($sformatf("bp e%0d valid", e), {31'b0, validd}, 32'h0);
                checkOutput($sformatf("bp e%0d instr", e), instrd, 32'h0000_0013);
            end
        end
        @(negedge clk);
        imem_ready = 1'b1;
        stepEdge();
        checkOutput("bp e12 valid", {31'b0, validd}, 32'h0);
        checkOutput("bp e12 addr", imem_addr, 32'h1C);
        stepEdge();
        checkOutput("bp e13 valid", {31'b0, validd}, 32'h0);
        stepEdge();
        checkOutput("bp e14 valid", {31'b0, validd}, 32'h1);
        checkOutput("bp e14 pcd", pcd, 32'h18);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf bubbles", fetch_bubbles, basePerf + 32'd5);
`endif
        @(negedge clk);
        stalld = 1'b1;
        repeat (3) stepEdge();
        checkOutput("bp stall pcd", pcd, 32'h18);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf stall hold", fetch_bubbles, basePerf + 32'd5);
`endif
        @(negedge clk);
        setIdle();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
